// File: rtl/o2k_mem_responder.sv
// ----------------------------------------------------------------------------
// o2k_mem_responder
//
// AXI4-MM slave for the oculink-to-kernel (o2k) port, backed by a local
// word-addressed memory. Write and read channels run independent FSMs against
// one register array and return B/R responses on their own.
//
// Optional feature (compile-time macro O2K_MEM_RANGE_CHECK_EN):
//   When defined, a burst whose byte span is not fully inside
//   [MEM_BASE, MEM_BASE + 16*2^MEM_LOG2_DEPTH) is flagged at AW/AR acceptance.
//   Flagged writes accept and drop every beat and answer SLVERR. Flagged reads
//   return zero data with SLVERR on every beat. When undefined, the index
//   simply wraps modulo the memory depth.
//
// Ports:
//   clk, rst                 single rising-edge clock, synchronous active-high reset
//   s_aw*                    write address: id, byte address, beats-1, valid/ready
//   s_w*                     write data, byte strobes, last flag, valid/ready
//   s_b*                     write response: echoed id, resp (0 OKAY, 2 SLVERR)
//   s_ar*                    read address: id, byte address, beats-1, valid/ready
//   s_r*                     read data, echoed id, resp, last flag, valid/ready
//   dbg_w_state/dbg_r_state  current write / read FSM state
//
// Handshake: a beat transfers on a cycle where valid and ready are both high.
// A valid, once raised, stays high with a stable payload until it is accepted.
// Ready signals are forced low while rst is high so nothing completes under
// reset.
// ----------------------------------------------------------------------------
module o2k_mem_responder #(
    parameter int                    ADDR_WIDTH     = 64,
    parameter int                    DATA_WIDTH     = 128,
    parameter int                    ID_WIDTH       = 4,
    parameter int                    MEM_LOG2_DEPTH = 9,
    parameter logic [ADDR_WIDTH-1:0] MEM_BASE       = '0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [ID_WIDTH-1:0]     s_awid,
    input  logic [ADDR_WIDTH-1:0]   s_awaddr,
    input  logic [7:0]              s_awlen,
    input  logic                    s_awvalid,
    output logic                    s_awready,
    input  logic [DATA_WIDTH-1:0]   s_wdata,
    input  logic [DATA_WIDTH/8-1:0] s_wstrb,
    input  logic                    s_wlast,
    input  logic                    s_wvalid,
    output logic                    s_wready,
    output logic [ID_WIDTH-1:0]     s_bid,
    output logic [1:0]              s_bresp,
    output logic                    s_bvalid,
    input  logic                    s_bready,
    input  logic [ID_WIDTH-1:0]     s_arid,
    input  logic [ADDR_WIDTH-1:0]   s_araddr,
    input  logic [7:0]              s_arlen,
    input  logic                    s_arvalid,
    output logic                    s_arready,
    output logic [ID_WIDTH-1:0]     s_rid,
    output logic [DATA_WIDTH-1:0]   s_rdata,
    output logic [1:0]              s_rresp,
    output logic                    s_rlast,
    output logic                    s_rvalid,
    input  logic                    s_rready,
    output logic [1:0]              dbg_w_state,
    output logic                    dbg_r_state
);

    localparam int         STRB_WIDTH  = DATA_WIDTH / 8;
    localparam int         DEPTH       = 1 << MEM_LOG2_DEPTH;
    localparam int         IDXW        = MEM_LOG2_DEPTH;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
    typedef enum logic       {R_IDLE, R_DATA}         r_state_t;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // ------------------------------------------------------------------
    // Address decode: word index relative to MEM_BASE, low nibble ignored
    // ------------------------------------------------------------------
    logic [ADDR_WIDTH-1:0] aw_off, ar_off;
    logic [IDXW-1:0]       aw_idx, ar_idx;
    logic                  aw_oor, ar_oor;
    logic                  unused_bits;

    assign aw_off      = s_awaddr - MEM_BASE;
    assign ar_off      = s_araddr - MEM_BASE;
    assign aw_idx      = aw_off[IDXW+3:4];
    assign ar_idx      = ar_off[IDXW+3:4];
    assign unused_bits = ^{aw_off[ADDR_WIDTH-1:IDXW+4], aw_off[3:0],
                           ar_off[ADDR_WIDTH-1:IDXW+4], ar_off[3:0],
                           s_awaddr[3:0], s_araddr[3:0]};

`ifdef O2K_MEM_RANGE_CHECK_EN
    localparam int AW1 = ADDR_WIDTH + 1;

    // The extra top bit catches addresses below MEM_BASE; the end-of-span
    // sum is done one bit wider so it cannot wrap past the window.
    function automatic logic span_outside(input logic [ADDR_WIDTH-5:0] addr_hi,
                                          input logic [7:0]            len);
        logic [ADDR_WIDTH:0] off;
        logic [ADDR_WIDTH:0] end_byte;
        off      = {1'b0, addr_hi, 4'b0000} - {1'b0, MEM_BASE};
        end_byte = off + ((AW1'(len) + AW1'(1)) << 4);
        return off[ADDR_WIDTH] || (end_byte > (AW1'(DEPTH) << 4));
    endfunction

    assign aw_oor = span_outside(s_awaddr[ADDR_WIDTH-1:4], s_awlen);
    assign ar_oor = span_outside(s_araddr[ADDR_WIDTH-1:4], s_arlen);
`else
    assign aw_oor = 1'b0;
    assign ar_oor = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Write channel
    // ------------------------------------------------------------------
    w_state_t            w_state_q, w_state_d;
    logic [ID_WIDTH-1:0] w_id_q;
    logic [7:0]          w_len_q;
    logic [IDXW-1:0]     w_idx_q;
    logic [8:0]          w_cnt_q;   // 9 bits so len=255 never overflows
    logic                w_err_q;
    logic                w_drop_q;
    logic                aw_fire, w_fire, w_cnt_is_len;
    logic [IDXW-1:0]     w_addr;

    assign w_cnt_is_len = (w_cnt_q == {1'b0, w_len_q});
    assign w_addr       = w_idx_q + IDXW'(w_cnt_q);
    assign s_bid        = w_id_q;
    assign dbg_w_state  = w_state_q;

    always_comb begin
        w_state_d = w_state_q;
        s_awready = 1'b0;
        s_wready  = 1'b0;
        s_bvalid  = 1'b0;
        s_bresp   = RESP_OKAY;
        aw_fire   = 1'b0;
        w_fire    = 1'b0;
        case (w_state_q)
            W_IDLE: begin
                s_awready = !rst;
                aw_fire   = s_awvalid && !rst;
                if (aw_fire) w_state_d = W_DATA;
            end
            W_DATA: begin
                s_wready = !rst;
                w_fire   = s_wvalid && !rst;
                // Burst ends on whichever comes first: wlast or the final counted beat.
                if (w_fire && (s_wlast || w_cnt_is_len)) w_state_d = W_RESP;
            end
            W_RESP: begin
                s_bvalid = 1'b1;
                s_bresp  = (w_err_q || w_drop_q) ? RESP_SLVERR : RESP_OKAY;
                if (s_bready) w_state_d = W_IDLE;
            end
            default: w_state_d = W_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            w_state_q <= W_IDLE;
            w_id_q    <= '0;
            w_len_q   <= '0;
            w_idx_q   <= '0;
            w_cnt_q   <= '0;
            w_err_q   <= 1'b0;
            w_drop_q  <= 1'b0;
        end else begin
            w_state_q <= w_state_d;
            if (aw_fire) begin
                w_id_q   <= s_awid;
                w_len_q  <= s_awlen;
                w_idx_q  <= aw_idx;
                w_cnt_q  <= '0;
                w_err_q  <= 1'b0;
                w_drop_q <= aw_oor;
            end
            if (w_fire) begin
                w_cnt_q <= w_cnt_q + 9'd1;
                // Only differs on the terminating beat: wlast early or missing.
                if (s_wlast != w_cnt_is_len) w_err_q <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_fire && !w_drop_q) begin
            for (int b = 0; b < STRB_WIDTH; b++) begin
                if (s_wstrb[b]) mem[w_addr][b*8 +: 8] <= s_wdata[b*8 +: 8];
            end
        end
    end

    // ------------------------------------------------------------------
    // Read channel. Data is prefetched into r_data_q one beat ahead, so a
    // same-cycle write to the word being fetched yields the old contents.
    // ------------------------------------------------------------------
    r_state_t              r_state_q, r_state_d;
    logic [ID_WIDTH-1:0]   r_id_q;
    logic [7:0]            r_len_q;
    logic [IDXW-1:0]       r_idx_q;
    logic [8:0]            r_cnt_q, r_cnt_nxt;
    logic                  r_drop_q;
    logic [DATA_WIDTH-1:0] r_data_q;
    logic                  r_last_q;
    logic [1:0]            r_resp_q;
    logic                  ar_fire, r_fire;
    logic [IDXW-1:0]       r_rd_idx;

    assign r_cnt_nxt   = r_cnt_q + 9'd1;
    assign r_rd_idx    = r_idx_q + IDXW'(r_cnt_nxt);
    assign s_rid       = r_id_q;
    assign s_rdata     = r_data_q;
    assign s_rlast     = r_last_q;
    assign s_rresp     = r_resp_q;
    assign dbg_r_state = r_state_q;

    always_comb begin
        r_state_d = r_state_q;
        s_arready = 1'b0;
        s_rvalid  = 1'b0;
        ar_fire   = 1'b0;
        r_fire    = 1'b0;
        case (r_state_q)
            R_IDLE: begin
                s_arready = !rst;
                ar_fire   = s_arvalid && !rst;
                if (ar_fire) r_state_d = R_DATA;
            end
            R_DATA: begin
                s_rvalid = 1'b1;
                r_fire   = s_rready;
                if (r_fire && r_last_q) r_state_d = R_IDLE;
            end
            default: r_state_d = R_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q <= R_IDLE;
            r_id_q    <= '0;
            r_len_q   <= '0;
            r_idx_q   <= '0;
            r_cnt_q   <= '0;
            r_drop_q  <= 1'b0;
            r_data_q  <= '0;
            r_last_q  <= 1'b0;
            r_resp_q  <= RESP_OKAY;
        end else begin
            r_state_q <= r_state_d;
            if (ar_fire) begin
                r_id_q   <= s_arid;
                r_len_q  <= s_arlen;
                r_idx_q  <= ar_idx;
                r_cnt_q  <= '0;
                r_drop_q <= ar_oor;
                r_data_q <= ar_oor ? '0 : mem[ar_idx];
                r_last_q <= (s_arlen == 8'd0);
                r_resp_q <= ar_oor ? RESP_SLVERR : RESP_OKAY;
            end else if (r_fire) begin
                if (r_last_q) begin
                    r_last_q <= 1'b0;
                    r_resp_q <= RESP_OKAY;
                end else begin
                    r_cnt_q  <= r_cnt_nxt;
                    r_data_q <= r_drop_q ? '0 : mem[r_rd_idx];
                    r_last_q <= (r_cnt_nxt == {1'b0, r_len_q});
                end
            end
        end
    end

endmodule
